// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_addsub_stage.sv
// Combinational add/subtract primitive: subtract is B inverted plus carry-in.
module div_addsub_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider (non-restoring, one quotient bit per cycle).
// Quotient truncates toward zero; remainder follows the dividend's sign.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_y;
  logic             as_sub;
  logic [WIDTH:0]   p_fix;

  function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Shared adder: shifted P in ITER (direction from P's sign before the shift),
  // unshifted P with add-back in FIX.
  assign p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign as_a   = (state_q == ITER) ? p_sh : p_q;
  assign as_sub = (state_q == ITER) && !p_q[WIDTH];

  div_addsub_stage #(.W(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   ({1'b0, dmag_q}),
    .sub (as_sub),
    .y   (as_y)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    q_d       = q_q;
    dmag_d    = dmag_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    p_fix     = p_q[WIDTH] ? as_y : p_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_neg_d = dividend[WIDTH-1];
          dvs_neg_d = divisor[WIDTH-1];
          q_d       = dividend[WIDTH-1] ? twos(dividend) : dividend;
          dmag_d    = divisor[WIDTH-1] ? twos(divisor) : divisor;
          p_d       = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            quot_d  = '0;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        p_d   = as_y;
        q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        p_d     = p_fix;
        quot_d  = (dvd_neg_q ^ dvs_neg_q) ? twos(q_q) : q_q;
        rem_d   = dvd_neg_q ? twos(p_fix[WIDTH-1:0]) : p_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      dmag_q    <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      dmag_q    <= dmag_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: vector table plus handshake/reset sequences.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  seq_divider dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Counts falling edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int k0, output int k, output bit busy_ok);
    bit got;
    got     = 1'b0;
    busy_ok = 1'b1;
    k       = k0;
    while (!got && k < 200) begin
      @(negedge clock);
      k++;
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_div(input vec_t v, input bit hold);
    int k;
    bit busy_ok;
    @(negedge clock);
    dividend = v.dvd;
    divisor  = v.dvs;
    start    = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    wait_done(0, k, busy_ok);
    check({v.name, "_latency"}, 32'(k), 32'(v.lat));
    check({v.name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    check({v.name, "_q"}, quotient, v.q);
    check({v.name, "_r"}, remainder, v.r);
    check({v.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, v.dbz});
    if (hold) begin
      @(posedge clock);
      #1 start = 1'b0;
    end
    @(negedge clock);
    check({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({v.name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int  k;
    bit  busy_ok;
    bit  saw_done;
    bit  idle_ok;
    vec_t v;

    vecs[0]  = '{"p100_p7",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{"n100_p7",    32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34};
    vecs[2]  = '{"p100_n7",    32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34};
    vecs[3]  = '{"n100_n7",    32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34};
    vecs[4]  = '{"p5_zero",    32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 1};
    vecs[5]  = '{"p9_p3",      32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 34};
    vecs[6]  = '{"minneg_n1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
    vecs[7]  = '{"p7_p9",      32'd7,          32'd9,          32'd0,          32'd7,          1'b0, 34};
    vecs[8]  = '{"n1_p1",      32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34};
    vecs[9]  = '{"max_max",    32'h7FFFFFFF,   32'h7FFFFFFF,   32'd1,          32'd0,          1'b0, 34};
    vecs[10] = '{"n5_zero",    32'hFFFFFFFB,   32'd0,          32'd0,          32'hFFFFFFFB,   1'b1, 1};

    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);

    for (int i = 0; i < 11; i++) run_div(vecs[i], 1'b0);

    // Start held high through DONE: exactly one operation, no re-acceptance.
    v = '{"p77_n10_hold", 32'd77, 32'hFFFFFFF6, 32'hFFFFFFF9, 32'd7, 1'b0, 34};
    run_div(v, 1'b1);
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (busy || done) idle_ok = 1'b0;
    end
    check("hold_no_rerun", {31'b0, idle_ok}, 32'd1);

    // Second start while busy is dropped.
    @(negedge clock);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    dividend = 32'd50;
    divisor  = 32'd6;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(3, k, busy_ok);
    check("busy_start_latency", 32'(k), 32'd34);
    check("busy_start_q", quotient, 32'd10);
    check("busy_start_r", remainder, 32'd0);
    @(negedge clock);
    check("busy_start_idle", {31'b0, busy}, 32'd0);

    // Clear ten cycles into ITER discards the operation.
    @(negedge clock);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("midclr_busy", {31'b0, busy}, 32'd0);
    check("midclr_done", {31'b0, done}, 32'd0);
    check("midclr_q", quotient, 32'd0);
    check("midclr_r", remainder, 32'd0);
    check("midclr_dbz", {31'b0, div_by_zero}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    check("midclr_no_done", {31'b0, saw_done}, 32'd0);

    v = '{"p20_p3_after_clr", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 34};
    run_div(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
